// File: rtl/cmd_pkg.sv
// Shared types and constants for the host command path: RX/TX framing
// states, decoder opcodes and response codes.
package cmd_pkg;

    typedef enum logic [1:0] {
        B1,
        B2,
        B3,
        HOLD
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    // Opcodes carried in cmd[23:16]
    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] SET_MASK = 8'h07;
    localparam logic [7:0] EEP_WRT  = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    // Single-byte responses returned by the decoder
    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] NEG_ACK  = 8'hEE;

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response transmit controller: latches one response byte, kicks the UART
// transmitter and reports completion back to the decoder.
module resp_tx_ctrl
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp_i,
    input  logic [7:0] resp_data_i,
    input  logic       tx_done_i,
    output logic [7:0] tx_data_o,
    output logic       trmt_o,
    output logic       resp_sent_o
);

    tx_state_t  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       trmt_q, trmt_d;
    logic       resp_sent_q, resp_sent_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // Next state: accept a request only when idle, finish on tx_done only when busy
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (send_resp_i) begin
                    tx_data_d = resp_data_i;
                    trmt_d    = 1'b1;
                    state_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done_i) begin
                    resp_sent_d = 1'b1;
                    state_d     = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_data_o   = tx_data_q;
    assign trmt_o      = trmt_q;
    assign resp_sent_o = resp_sent_q;

endmodule

// File: rtl/cmd_resp_bridge.sv
// Host framing bridge: assembles three UART bytes into a 24-bit command with
// an inter-byte timeout, and forwards the decoder's response byte to the UART.
module cmd_resp_bridge
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        resp_sent,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rx_state_t         state_q, state_d;
    logic [23:0]       cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              clr_rx_rdy_q, clr_rx_rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              take;

    // A byte is taken only when the previous clear is not still in flight,
    // since rx_rdy is still high during the clr_rx_rdy cycle.
    assign take = rx_rdy && !clr_rx_rdy_q;

    // RX state, command register, handshake outputs and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= B1;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            cnt_q        <= cnt_d;
        end
    end

    // Framing: capture byte per state, time out partial frames, hold until cleared
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        clr_rx_rdy_d = 1'b0;
        cnt_d        = cnt_q;
        unique case (state_q)
            B1: begin
                if (take) begin
                    cmd_d[23:16] = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = B2;
                end
            end
            B2: begin
                if (take) begin
                    cmd_d[15:8]  = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = B3;
                end else if (cnt_q == TO_LAST) begin
                    state_d = B1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            B3: begin
                if (take) begin
                    cmd_d[7:0]   = rx_data;
                    clr_rx_rdy_d = 1'b1;
                    cnt_d        = '0;
                    cmd_rdy_d    = 1'b1;
                    state_d      = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = B1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = B1;
                end
            end
            default: state_d = B1;
        endcase
    end

    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign clr_rx_rdy = clr_rx_rdy_q;

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_resp_i (send_resp),
        .resp_data_i (resp_data),
        .tx_done_i   (tx_done),
        .tx_data_o   (tx_data),
        .trmt_o      (trmt),
        .resp_sent_o (resp_sent)
    );

endmodule
